// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake, iterative multiply and sticky overflow
module alu_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carryout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Illegal,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1111;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic               illegal_q, illegal_d, sticky_q, sticky_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    logic               is_sub, is_addsub, alu_cy, alu_ov, alu_il, accept, sticky_set;
    logic [WIDTH-1:0]   b_eff, alu_res;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign Result     = result_q;
    assign Carryout   = carry_q;
    assign Overflow   = ovf_q;
    assign Zero       = zero_q;
    assign Illegal    = illegal_q;
    assign ovf_sticky = sticky_q;

    // Single-cycle datapath; SUB reuses the adder as A + ~B + 1 so its carry means "no borrow"
    always_comb begin
        is_sub    = Ctrl == OP_SUB;
        is_addsub = is_sub || Ctrl == OP_ADD;
        b_eff     = is_sub ? ~B : B;
        sum       = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        sh        = A[SHW-1:0];
        alu_cy    = is_addsub & sum[WIDTH];
        alu_ov    = is_addsub & (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
        alu_il    = 1'b0;
        case (Ctrl)
            OP_AND:         alu_res = A & B;
            OP_OR:          alu_res = A | B;
            OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
            OP_XOR:         alu_res = A ^ B;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SRL:         alu_res = B >> sh;
            OP_SRA:         alu_res = $signed(B) >>> sh;
            OP_MUL:         alu_res = '0;
            OP_NOR:         alu_res = ~(A | B);
            OP_SLL:         alu_res = B << sh;
            default: begin
                alu_res = '0;
                alu_il  = 1'b1;
            end
        endcase
    end

    // Handshake FSM: loads single-cycle results directly, or runs one shift-add step per cycle for MUL
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        sticky_set  = 1'b0;
        acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (accept && Ctrl == OP_MUL) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = SHW'(WIDTH - 1);
                    state_d  = MUL_BUSY;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    carry_d     = alu_cy;
                    ovf_d       = alu_ov;
                    zero_d      = alu_res == '0;
                    illegal_d   = alu_il;
                    sticky_set  = alu_ov;
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    result_d    = acc_step[WIDTH-1:0];
                    carry_d     = 1'b0;
                    ovf_d       = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d      = acc_step[WIDTH-1:0] == '0;
                    illegal_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sticky_d = sticky_set | (sticky_q & ~clr_sticky);
    end

    // State and result registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: vector table, hand sequences and randomized model check for alu_pipe
module tb_alu_pipe;
    localparam int W = 32;
    localparam logic [3:0] ADD = 4'b0010, MUL = 4'b1010;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, clr_sticky = 0;
    logic in_ready, out_valid, Carryout, Overflow, Zero, Illegal, ovf_sticky;
    logic [W-1:0] A = 0, B = 0, Result;
    logic [3:0] Ctrl = 0;
    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  c;
        logic [35:0] e;
        string       n;
    } vec_t;
    vec_t v[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Ctrl(Ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Carryout(Carryout), .Overflow(Overflow), .Zero(Zero),
        .Illegal(Illegal), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: {result, carry, overflow, zero, illegal} from plain integer arithmetic
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint d = 0;
        logic [63:0] p;
        logic [31:0] r = 0;
        logic cy = 0, ov = 0, il = 0;
        int sh = int'(a[4:0]);
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                p = 64'(a) + 64'(b);
                r = p[31:0];
                cy = p[32];
                d = sa + sb;
                ov = d != longint'($signed(d[31:0]));
            end
            4'd3:  r = a ^ b;
            4'd6: begin
                r = a - b;
                cy = a >= b;
                d = sa - sb;
                ov = d != longint'($signed(d[31:0]));
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = b >> sh;
            4'd9:  r = $signed(b) >>> sh;
            4'd10: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
                ov = p[63:32] != 0;
            end
            4'd12: r = ~(a | b);
            4'd15: r = b << sh;
            default: il = 1;
        endcase
        return {r, cy, ov, r == 0, il};
    endfunction

    // Issue one op (out_ready held high), wait for its result within a bound, check latency and outputs
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                          input logic [35:0] exp, input string name);
        int n = 0, lat = 0, rdy_hi = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({name, " in_ready"}, 64'(in_ready), 1);
        A = a; B = b; Ctrl = c; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; clr_sticky = 0;
        while (!out_valid && lat < 100) begin
            rdy_hi += int'(in_ready);
            @(posedge clk); #1; lat++;
        end
        check({name, " latency"}, 64'(lat), (c == MUL) ? 64'(W) : 64'd0);
        check({name, " busy_ready"}, 64'(rdy_hi), 0);
        check({name, " out"}, 64'({out_valid, Result, Carryout, Overflow, Zero, Illegal}), 64'({1'b1, exp}));
    endtask

    initial begin
        logic [31:0] ea, eb, held;
        logic seen;
        v.push_back('{32'h7FFFFFFF, 32'h1,        4'b0010, {32'h80000000, 4'b0100}, "add_ovf"});
        v.push_back('{32'h5,        32'h5,        4'b0110, {32'h0,        4'b1010}, "sub_eq"});
        v.push_back('{32'hFFFFFFFF, 32'h1,        4'b0111, {32'h1,        4'b0000}, "slt_neg"});
        v.push_back('{32'h1,        32'hFFFFFFFF, 4'b0111, {32'h0,        4'b0010}, "slt_pos"});
        v.push_back('{32'h4,        32'h80000000, 4'b1001, {32'hF8000000, 4'b0000}, "sra"});
        v.push_back('{32'h4,        32'h80000000, 4'b1000, {32'h08000000, 4'b0000}, "srl"});
        v.push_back('{32'd33,       32'h1,        4'b1111, {32'h2,        4'b0000}, "sll_wrap"});
        v.push_back('{32'hF0F0,     32'hFF00,     4'b0000, {32'hF000,     4'b0000}, "and"});
        v.push_back('{32'hF0F0,     32'hFF00,     4'b0001, {32'hFFF0,     4'b0000}, "or"});
        v.push_back('{32'hF0F0,     32'hFF00,     4'b0011, {32'h0FF0,     4'b0000}, "xor"});
        v.push_back('{32'h0,        32'h0,        4'b1100, {32'hFFFFFFFF, 4'b0000}, "nor"});
        v.push_back('{32'h0,        32'h1,        4'b0110, {32'hFFFFFFFF, 4'b0000}, "sub_borrow"});
        v.push_back('{32'h80000000, 32'h1,        4'b0110, {32'h7FFFFFFF, 4'b1100}, "sub_ovf"});
        v.push_back('{32'hFFFFFFFF, 32'h1,        4'b0010, {32'h0,        4'b1010}, "add_carry"});
        v.push_back('{32'h00010000, 32'h00010000, 4'b1010, {32'h0,        4'b0110}, "mul_ovf"});
        v.push_back('{32'd7,        32'd6,        4'b1010, {32'd42,       4'b0000}, "mul_small"});
        v.push_back('{32'h1234,     32'h5678,     4'b0100, {32'h0,        4'b0011}, "illegal"});

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 64'({out_valid, Result, Carryout, Overflow, Zero, Illegal, ovf_sticky}),
              64'({1'b0, 32'h0, 4'b0010, 1'b0}));
        rst = 0;
        #1;
        check("reset_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        foreach (v[i]) run_op(v[i].a, v[i].b, v[i].c, v[i].e, v[i].n);

        run_op(32'h7FFFFFFF, 32'h1, ADD, model(32'h7FFFFFFF, 32'h1, ADD), "st_add");
        check("sticky_set", 64'(ovf_sticky), 1);
        clr_sticky = 1;
        @(posedge clk); #1;
        clr_sticky = 0;
        check("sticky_clr", 64'(ovf_sticky), 0);
        run_op(32'h1, 32'h1, ADD, model(32'h1, 32'h1, ADD), "st_noovf");
        check("sticky_noovf", 64'(ovf_sticky), 0);
        run_op(32'h00010000, 32'h00010000, MUL, model(32'h00010000, 32'h00010000, MUL), "st_mul");
        check("sticky_mul", 64'(ovf_sticky), 0);
        clr_sticky = 1;
        run_op(32'h80000000, 32'h80000000, ADD, model(32'h80000000, 32'h80000000, ADD), "st_both");
        check("sticky_set_wins", 64'(ovf_sticky), 1);

        for (int i = 0; i < 8; i++) begin
            ea = 32'(i) * 32'h11111111;
            eb = 32'(i + 5);
            A = ea; B = eb; Ctrl = ADD; in_valid = 1;
            @(posedge clk); #1;
            check("b2b", 64'({out_valid, Result}), 64'({1'b1, ea + eb}));
        end
        held = Result;
        out_ready = 0;
        A = 32'd100; B = 32'd23;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 64'(in_ready), 0);
            @(posedge clk); #1;
            check("stall_hold", 64'({out_valid, Result}), 64'({1'b1, held}));
        end
        out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        check("resume", 64'({out_valid, Result}), 64'({1'b1, 32'd123}));
        @(posedge clk); #1;
        check("drained", 64'(out_valid), 0);

        A = 32'd7; B = 32'd6; Ctrl = MUL; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_busy", 64'(in_ready), 0);
        rst = 1;
        #1;
        check("mid_mul_reset", 64'({out_valid, Result, Carryout, Overflow, Zero, Illegal, ovf_sticky}),
              64'({1'b0, 32'h0, 4'b0010, 1'b0}));
        @(posedge clk); #1;
        rst = 0;
        #1;
        check("post_reset_ready", 64'(in_ready), 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("aborted_no_emit", 64'(seen), 0);
        run_op(32'd3, 32'd4, ADD, model(32'd3, 32'd4, ADD), "after_abort");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            logic [3:0] rc;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            run_op(ra, rb, rc, model(ra, rb, rc), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
